// File: rtl/fp_norm_share_pkg.sv
// Shared FPU normalization types and constants.
package fp_norm_share_pkg;

  localparam int FP_WIDTH = 48;
  localparam int FP_EXP_W = 10;
  localparam int FP_TAG_W = 5;
  localparam int FP_LZC_W = $clog2(FP_WIDTH + 1);

  // One normalization request as captured in stage A.
  typedef struct packed {
    logic        [FP_WIDTH-1:0] mant;
    logic signed [FP_EXP_W-1:0] exp;
    logic        [FP_TAG_W-1:0] tag;
  } fp_norm_req_t;

endpackage

// File: rtl/fp_norm_share_lzc.sv
// Leading-zero counter: returns WIDTH for an all-zero vector.
module fp_lzc import fp_norm_share_pkg::*; #(
  parameter int WIDTH = FP_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_is_zero
);

  // Scan upward so the highest set bit determines the count.
  always_comb begin
    o_cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_vec[i]) o_cnt = CNT_W'(WIDTH - 1 - i);
    end
  end

  assign o_is_zero = ~|i_vec;

endmodule

// File: rtl/fp_norm_share.sv
// Shared normalizer: round-robin arbiter, stage A capture, stage B lzc/shift.
module fp_norm_share import fp_norm_share_pkg::*; #(
  parameter int WIDTH   = FP_WIDTH,
  parameter int EXP_W   = FP_EXP_W,
  parameter int TAG_W   = FP_TAG_W,
  parameter int NUM_REQ = 2,
  localparam int SRC_W  = $clog2(NUM_REQ)
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_flush,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  output logic [NUM_REQ-1:0]              o_req_ready,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   i_req_mant,
  input  logic [NUM_REQ-1:0][EXP_W-1:0]   i_req_exp,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]   i_req_tag,
  output logic                            o_rsp_valid,
  input  logic                            i_rsp_ready,
  output logic [WIDTH-1:0]                o_rsp_mant,
  output logic [EXP_W-1:0]                o_rsp_exp,
  output logic                            o_rsp_zero,
  output logic                            o_rsp_ovf,
  output logic [SRC_W-1:0]                o_rsp_src,
  output logic [TAG_W-1:0]                o_rsp_tag
);

  localparam int LZC_W = $clog2(WIDTH + 1);

  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] grant_idx;
  logic             grant_found;
  logic [SRC_W:0]   arb_idx;

  logic             a_valid;
  fp_norm_req_t     a_req;
  logic [SRC_W-1:0] a_src;

  logic             b_take;
  logic             b_load;
  logic             a_can_load;
  logic             accept;

  logic [LZC_W-1:0] lzc;
  logic             lzc_zero;
  logic [WIDTH-1:0] b_mant;
  logic [EXP_W:0]   b_diff;
  logic             b_ovf;

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    arb_idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_idx = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (arb_idx >= (SRC_W+1)'(NUM_REQ)) arb_idx = arb_idx - (SRC_W+1)'(NUM_REQ);
      if (!grant_found && i_req_valid[arb_idx[SRC_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = arb_idx[SRC_W-1:0];
      end
    end
  end

  assign b_take     = o_rsp_valid && i_rsp_ready;
  assign b_load     = a_valid && (!o_rsp_valid || b_take);
  assign a_can_load = !a_valid || b_load;

  // Ready is one-hot on the granted requester; held low through reset and flush.
  always_comb begin
    o_req_ready = '0;
    if (grant_found && a_can_load && !i_flush && i_rst_n) o_req_ready[grant_idx] = 1'b1;
  end

  assign accept = |o_req_ready;

  // Pointer moves past the accepted requester only on an actual accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    rr_ptr <= '0;
    else if (accept) rr_ptr <= (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Stage A: capture the granted request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_valid <= 1'b0;
      a_req   <= '0;
      a_src   <= '0;
    end else if (i_flush) begin
      a_valid <= 1'b0;
    end else if (accept) begin
      a_valid  <= 1'b1;
      a_req.mant <= i_req_mant[grant_idx];
      a_req.exp  <= i_req_exp[grant_idx];
      a_req.tag  <= i_req_tag[grant_idx];
      a_src    <= grant_idx;
    end else if (b_load) begin
      a_valid <= 1'b0;
    end
  end

  fp_lzc #(.WIDTH(WIDTH), .CNT_W(LZC_W)) u_lzc (
    .i_vec     (a_req.mant),
    .o_cnt     (lzc),
    .o_is_zero (lzc_zero)
  );

  // Exponent subtract is one bit wider so overflow shows as a sign disagreement.
  assign b_mant = a_req.mant << lzc;
  assign b_diff = {a_req.exp[EXP_W-1], a_req.exp} - (EXP_W+1)'(lzc);
  assign b_ovf  = b_diff[EXP_W] ^ b_diff[EXP_W-1];

  // Stage B: register the normalized result; fields hold until handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_valid <= 1'b0;
      o_rsp_mant  <= '0;
      o_rsp_exp   <= '0;
      o_rsp_zero  <= 1'b0;
      o_rsp_ovf   <= 1'b0;
      o_rsp_src   <= '0;
      o_rsp_tag   <= '0;
    end else if (i_flush) begin
      o_rsp_valid <= 1'b0;
    end else if (b_load) begin
      o_rsp_valid <= 1'b1;
      o_rsp_mant  <= lzc_zero ? '0 : b_mant;
      o_rsp_exp   <= lzc_zero ? '0 : b_diff[EXP_W-1:0];
      o_rsp_zero  <= lzc_zero;
      o_rsp_ovf   <= lzc_zero ? 1'b0 : b_ovf;
      o_rsp_src   <= a_src;
      o_rsp_tag   <= a_req.tag;
    end else if (b_take) begin
      o_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_norm_share.sv
// Randomized bench for fp_norm_share against an ordered-response reference model.
module tb_fp_norm_share;

  logic                clk;
  logic                rst_n;
  logic                flush;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0][47:0]    req_mant;
  logic [1:0][9:0]     req_exp;
  logic [1:0][4:0]     req_tag;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [47:0]         rsp_mant;
  logic [9:0]          rsp_exp;
  logic                rsp_zero;
  logic                rsp_ovf;
  logic [0:0]          rsp_src;
  logic [4:0]          rsp_tag;

  fp_norm_share #(.WIDTH(48), .EXP_W(10), .TAG_W(5), .NUM_REQ(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flush     (flush),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_mant  (req_mant),
    .i_req_exp   (req_exp),
    .i_req_tag   (req_tag),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_mant  (rsp_mant),
    .o_rsp_exp   (rsp_exp),
    .o_rsp_zero  (rsp_zero),
    .o_rsp_ovf   (rsp_ovf),
    .o_rsp_src   (rsp_src),
    .o_rsp_tag   (rsp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] mant;
    logic [9:0]  exp;
    logic        zero;
    logic        ovf;
    logic        src;
    logic [4:0]  tag;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   m_ptr = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   dut_acc_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Normalize by repeated doubling and plain integer exponent arithmetic.
  function automatic exp_t normalize(input logic [47:0] m, input logic [9:0] e);
    exp_t r;
    int   l;
    int   ev;
    r.mant = m;
    r.zero = (m == 48'd0);
    r.exp  = 10'd0;
    r.ovf  = 1'b0;
    r.src  = 1'b0;
    r.tag  = 5'd0;
    r.acc  = 0;
    if (m != 48'd0) begin
      l = 0;
      while (!r.mant[47]) begin
        r.mant = r.mant << 1;
        l++;
      end
      ev    = int'($signed(e)) - l;
      r.ovf = (ev < -512) || (ev > 511);
      r.exp = ev[9:0];
    end
    return r;
  endfunction

  // One clock cycle: drive, check at negedge, update model at posedge.
  task automatic cyc_step(input logic [1:0] v, input logic rr, input logic fl);
    logic       exp_rv;
    logic [1:0] exp_rdy;
    int         g;
    bit         deliver;
    exp_t       e;
    req_valid = v;
    rsp_ready = rr;
    flush     = fl;
    @(negedge clk);
    exp_rv = (sb.size() > 0) && (cyc >= sb[0].acc + 2);
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (exp_rv && rsp_valid) begin
      chk("rsp_mant", 64'(rsp_mant), 64'(sb[0].mant));
      chk("rsp_exp",  64'(rsp_exp),  64'(sb[0].exp));
      chk("rsp_zero", 64'(rsp_zero), 64'(sb[0].zero));
      chk("rsp_ovf",  64'(rsp_ovf),  64'(sb[0].ovf));
      chk("rsp_src",  64'(rsp_src),  64'(sb[0].src));
      chk("rsp_tag",  64'(rsp_tag),  64'(sb[0].tag));
    end
    g = -1;
    exp_rdy = 2'b00;
    if (!fl && (sb.size() < 2 || rr)) begin
      for (int k = 0; k < 2; k++) begin
        int j;
        j = (m_ptr + k) % 2;
        if (g < 0 && v[j]) g = j;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (req_ready != 2'b00) dut_acc_cnt++;
    deliver = exp_rv && rr;
    if (g >= 0) begin
      e     = normalize(req_mant[g], req_exp[g]);
      e.src = g[0];
      e.tag = req_tag[g];
      e.acc = cyc;
    end
    @(posedge clk);
    if (deliver) void'(sb.pop_front());
    if (fl) sb.delete();
    else if (g >= 0) begin
      sb.push_back(e);
      m_ptr = (g + 1) % 2;
    end
    cyc++;
    #1;
  endtask

  task automatic rand_data();
    logic [47:0] t;
    for (int i = 0; i < 2; i++) begin
      t = 48'({$urandom(), $urandom()});
      req_mant[i] = t >> $urandom_range(0, 48);
      req_exp[i]  = 10'($urandom());
      req_tag[i]  = 5'($urandom());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    req_mant  = '0;
    req_exp   = '0;
    req_tag   = '0;

    // Reset state, with requests offered while reset is held
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_mant",  64'(rsp_mant),  64'd0);
    chk("rst_rsp_exp",   64'(rsp_exp),   64'd0);
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request: lzc=16
    req_mant[0] = 48'h0000_8000_0000;
    req_exp[0]  = 10'd100;
    req_tag[0]  = 5'h15;
    cyc_step(2'b01, 1'b1, 1'b0);
    cyc_step(2'b00, 1'b1, 1'b0);
    chk("t1_valid", 64'(rsp_valid), 64'd1);
    chk("t1_mant",  64'(rsp_mant),  64'h8000_0000_0000);
    chk("t1_exp",   64'(rsp_exp),   64'd84);
    chk("t1_zero",  64'(rsp_zero),  64'd0);
    chk("t1_src",   64'(rsp_src),   64'd0);
    chk("t1_tag",   64'(rsp_tag),   64'h15);
    cyc_step(2'b00, 1'b1, 1'b0);

    // Zero mantissa from requester 1 (pointer now at 1)
    req_mant[1] = 48'd0;
    req_exp[1]  = 10'h3FB;
    req_tag[1]  = 5'h0A;
    cyc_step(2'b10, 1'b1, 1'b0);
    cyc_step(2'b00, 1'b1, 1'b0);
    chk("z_zero", 64'(rsp_zero), 64'd1);
    chk("z_exp",  64'(rsp_exp),  64'd0);
    chk("z_mant", 64'(rsp_mant), 64'd0);
    chk("z_ovf",  64'(rsp_ovf),  64'd0);
    chk("z_src",  64'(rsp_src),  64'd1);

    // Exponent underflow: -500 - 47 wraps to 477
    req_mant[0] = 48'd1;
    req_exp[0]  = 10'h20C;
    cyc_step(2'b01, 1'b1, 1'b0);
    cyc_step(2'b00, 1'b1, 1'b0);
    chk("o_ovf",  64'(rsp_ovf),  64'd1);
    chk("o_exp",  64'(rsp_exp),  64'd477);
    chk("o_mant", 64'(rsp_mant), 64'h8000_0000_0000);
    cyc_step(2'b00, 1'b1, 1'b0);

    // Both valid continuously: grants alternate, full throughput
    dut_acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      cyc_step(2'b11, 1'b1, 1'b0);
    end
    chk("alt_accepts", 64'(dut_acc_cnt), 64'd8);
    cyc_step(2'b00, 1'b1, 1'b0);
    cyc_step(2'b00, 1'b1, 1'b0);

    // Backpressure: only two entries fit
    dut_acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      cyc_step(2'b01, 1'b0, 1'b0);
    end
    chk("bp_accepts", 64'(dut_acc_cnt), 64'd2);
    for (int i = 0; i < 3; i++) cyc_step(2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc_step(2'b00, 1'b1, 1'b0);

    // Flush with both stages full and a request pending
    rand_data();
    cyc_step(2'b11, 1'b0, 1'b0);
    cyc_step(2'b11, 1'b0, 1'b0);
    cyc_step(2'b11, 1'b0, 1'b1);
    chk("flush_rsp_valid", 64'(rsp_valid), 64'd0);
    cyc_step(2'b11, 1'b1, 1'b0);
    cyc_step(2'b00, 1'b1, 1'b0);
    cyc_step(2'b00, 1'b1, 1'b0);

    // Asynchronous reset mid-stream
    rand_data();
    cyc_step(2'b11, 1'b0, 1'b0);
    cyc_step(2'b11, 1'b0, 1'b0);
    chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
    sb.delete();
    m_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc_step(2'b11, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_data();
      cyc_step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 49) == 0));
    end
    for (int i = 0; i < 4; i++) cyc_step(2'b00, 1'b1, 1'b0);
    chk("final_rsp_valid", 64'(rsp_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
